// File: rtl/lut_cfg_neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_neuron_pkg
//  Description : Shared definitions for the run-time-loadable LUT neuron.
//                Default table geometry and the two-state load/run FSM
//                encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package lut_neuron_pkg;

    // Default neuron input width (table address) and output width (table word)
    localparam int C_IN_BITS  = 8;
    localparam int C_OUT_BITS = 1;

    // Table load / inference mode
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : lut_neuron_pkg
`default_nettype wire

// File: rtl/lut_cfg_neuron_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lut_cfg_ram
//  Description : DEPTH x OUT_BITS distributed truth-table RAM with one
//                synchronous write port and one synchronous read port.
//                Only the read register is reset; the table is not.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                we/waddr/wdata  - write port
//                re/raddr        - read enable / address
//                rdata           - registered read data (holds when re=0)
//  Revision    : 1.0  initial release
// ============================================================================
module lut_cfg_ram #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic                re,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int DEPTH = 2 ** IN_BITS;

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] r_mem [DEPTH];
    logic [OUT_BITS-1:0] r_rdata;

    // Table contents carry no reset so the array maps onto LUT RAM
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between lookups
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : lut_cfg_ram
`default_nettype wire

// File: rtl/lut_cfg_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lut_cfg_neuron
//  Description : Run-time programmable truth-table neuron. A serial config
//                stream loads the 2**IN_BITS-entry table; afterwards each
//                in_valid performs a registered one-cycle lookup.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                cfg_start                     - restart load at address 0
//                cfg_valid/cfg_ready/cfg_data  - config word handshake
//                cfg_last                      - final word marker
//                cfg_done / cfg_err            - loaded / sticky framing error
//                in_valid / in_data            - inference request
//                out_valid / out_data          - registered lookup result
//  Revision    : 1.0  initial release
// ============================================================================
module lut_cfg_neuron
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = C_IN_BITS,
    parameter int OUT_BITS = C_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int                 DEPTH      = 2 ** IN_BITS;
    localparam logic [IN_BITS-1:0] C_LAST_ADR = IN_BITS'(DEPTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_BITS-1:0]   r_addr;
    logic                 r_done;
    logic                 r_err;
    logic                 r_out_valid;

    logic                 w_cfg_ready;
    logic                 w_we;
    logic                 w_re;
    logic                 w_at_end;
    logic                 w_frame_err;
    logic                 w_load_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (cfg_start) begin
            w_state_nxt = ST_LOAD;
        end else if ((r_state == ST_LOAD) && w_load_ok) begin
            w_state_nxt = ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs / strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_ready = (r_state == ST_LOAD);
        // cfg_start wins over a same-cycle word or lookup
        w_we        = w_cfg_ready && cfg_valid && !cfg_start;
        w_re        = (r_state == ST_RUN) && in_valid && !cfg_start;
        w_at_end    = (r_addr == C_LAST_ADR);
        // cfg_last must coincide exactly with the final address
        w_frame_err = w_we && (cfg_last != w_at_end);
        // A correctly framed final word only completes a load that has not
        // already been voided; a voided load needs cfg_start to recover.
        w_load_ok   = w_we && w_at_end && cfg_last && !r_err;
    end

    // ------------------------------------------------------------------
    // Address counter, status flags and result-valid pipeline bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (cfg_start) begin
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_re;
            if (w_we) begin
                // Natural wrap returns the counter to 0 after the last word
                r_addr <= w_frame_err ? '0 : r_addr + IN_BITS'(1);
            end
            if (w_frame_err) begin
                r_err <= 1'b1;
            end
            if (w_load_ok) begin
                r_done <= 1'b1;
            end
        end
    end

    lut_cfg_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (r_addr),
        .wdata (cfg_data),
        .re    (w_re),
        .raddr (in_data),
        .rdata (out_data)
    );

    assign cfg_ready = w_cfg_ready;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign out_valid = r_out_valid;

endmodule : lut_cfg_neuron
`default_nettype wire

// File: tb/tb_lut_cfg_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_cfg_neuron
//  Description : Self-checking bench for lut_cfg_neuron against a
//                behavioural table/flag model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lut_cfg_neuron;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int DEPTH    = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_last;
    logic                cfg_done;
    logic                cfg_err;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    always #5 clk = ~clk;

    lut_cfg_neuron #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Reference model
    bit                  m_run;
    bit                  m_err;
    bit                  m_done;
    bit                  m_ov;
    logic [OUT_BITS-1:0] m_od;
    int                  m_addr;
    logic [OUT_BITS-1:0] m_tab [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, using the inputs seen at the edge
    task automatic model_step();
        if (rst) begin
            m_run = 0; m_addr = 0; m_err = 0; m_done = 0; m_ov = 0; m_od = '0;
        end else if (cfg_start) begin
            m_run = 0; m_addr = 0; m_err = 0; m_done = 0; m_ov = 0;
        end else if (!m_run) begin
            m_ov = 0;
            if (cfg_valid) begin
                m_tab[m_addr] = cfg_data;
                if (cfg_last != (m_addr == DEPTH - 1)) begin
                    m_err  = 1;
                    m_addr = 0;
                end else if (m_addr == DEPTH - 1) begin
                    if (!m_err) begin
                        m_run  = 1;
                        m_done = 1;
                    end
                    m_addr = 0;
                end else begin
                    m_addr = m_addr + 1;
                end
            end
        end else begin
            m_ov = in_valid;
            if (in_valid) m_od = m_tab[in_data];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(!m_run));
        check("cfg_done",  32'(cfg_done),  32'(m_done));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data",  32'(out_data),  32'(m_od));
    endtask

    task automatic idle();
        rst = 0; cfg_start = 0; cfg_valid = 0; cfg_data = '0; cfg_last = 0;
        in_valid = 0; in_data = '0;
    endtask

    function automatic logic [OUT_BITS-1:0] pat(input int mode, input int k);
        logic [31:0] kv;
        kv = k;
        case (mode)
            0:       return OUT_BITS'(kv[7] ^ kv[0]);
            1:       return '1;
            default: return OUT_BITS'($urandom);
        endcase
    endfunction

    // Stream n handshakes; cfg_last on handshake index last_idx (-1 = never)
    task automatic load_words(input int n, input int last_idx, input int mode, input bit gaps);
        int k;
        k = 0;
        while (k < n) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                cfg_valid = 0;
                cfg_data  = OUT_BITS'($urandom);
                cfg_last  = 1'($urandom);
            end else begin
                cfg_valid = 1;
                cfg_data  = pat(mode, k);
                cfg_last  = (k == last_idx);
                k++;
            end
            step();
        end
        cfg_valid = 0;
        cfg_last  = 0;
    endtask

    task automatic lookup(input logic [IN_BITS-1:0] a);
        in_valid = 1;
        in_data  = a;
        step();
        in_valid = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        step();
        rst = 0;

        // 1: parity-pattern load, then spot lookups
        load_words(DEPTH, DEPTH - 1, 0, 1'b0);
        check("tp1_done",  32'(cfg_done),  32'd1);
        check("tp1_ready", 32'(cfg_ready), 32'd0);
        lookup(8'h81);
        check("tp1_81", 32'(out_data), 32'd0);
        lookup(8'h01);
        check("tp1_01", 32'(out_data), 32'd1);
        lookup(8'h80);
        check("tp1_80_v", 32'(out_valid), 32'd1);
        check("tp1_80",   32'(out_data),  32'd1);
        step();
        check("tp1_idle_v", 32'(out_valid), 32'd0);

        // 2: back-to-back sweep, then random traffic
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1;
            in_data  = IN_BITS'(i);
            step();
        end
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom);
            in_data   = IN_BITS'($urandom);
            cfg_valid = 1'($urandom);
            cfg_data  = OUT_BITS'($urandom);
            step();
        end
        idle();

        // 3: early cfg_last, then recover with a random-data load
        cfg_start = 1;
        step();
        cfg_start = 0;
        load_words(101, 100, 2, 1'b0);
        check("tp3_err",  32'(cfg_err),  32'd1);
        check("tp3_done", 32'(cfg_done), 32'd0);
        cfg_start = 1;
        step();
        cfg_start = 0;
        load_words(DEPTH, DEPTH - 1, 2, 1'b0);
        check("tp3_err2",  32'(cfg_err),  32'd0);
        check("tp3_done2", 32'(cfg_done), 32'd1);
        for (int i = 0; i < 64; i++) lookup(IN_BITS'($urandom));

        // 4: missing cfg_last, inference ignored while stuck in LOAD
        cfg_start = 1;
        step();
        cfg_start = 0;
        load_words(DEPTH, -1, 2, 1'b0);
        check("tp4_err", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 8; i++) lookup(IN_BITS'($urandom));
        check("tp4_ov", 32'(out_valid), 32'd0);

        // 5: cfg_start with in_valid in RUN
        cfg_start = 1;
        step();
        cfg_start = 0;
        load_words(DEPTH, DEPTH - 1, 0, 1'b0);
        cfg_start = 1;
        in_valid  = 1;
        in_data   = 8'h01;
        step();
        cfg_start = 0;
        in_valid  = 0;
        check("tp5_ov",   32'(out_valid), 32'd0);
        check("tp5_done", 32'(cfg_done),  32'd0);
        load_words(DEPTH, DEPTH - 1, 1, 1'b0);
        lookup(8'h00);
        check("tp5_00", 32'(out_data), 32'd1);

        // 6: reset mid-load, then a gapped reload
        cfg_start = 1;
        step();
        cfg_start = 0;
        load_words(50, -1, 2, 1'b0);
        rst = 1;
        step();
        rst = 0;
        load_words(DEPTH, DEPTH - 1, 2, 1'b1);
        check("tp6_done", 32'(cfg_done), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'($urandom);
            in_data  = IN_BITS'(i);
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lut_cfg_neuron
`default_nettype wire
